// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-ported memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic       PORT_IF    = 1'b0;
    localparam logic       PORT_MEM   = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       enable,
    output logic [1:0] gnt_onehot,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx    = (req == 2'b11) ? ~last_gnt : req[1];
        gnt_onehot = 2'b00;
        if (enable && (req != 2'b00))
            gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported memory between instruction fetch (port 0) and load/store (port 1),
// one transaction at a time, with a fixed-latency read path and a one-cycle response pulse.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp0_err,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [3:0]    req1_wstrb,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          rsp1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_e        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          gnt_q, gnt_n;
    logic          last_gnt, last_gnt_n;
    logic          err_q, err_n;
    logic          we_q, we_n;
    logic [DW-1:0] rdata_q, rdata_n;

    logic [1:0]    gnt_onehot;
    logic          gnt_idx;
    logic          accept;
    logic          mis;
    logic          mem_go;
    logic [AW-1:0] sel_addr;
    logic          in_resp;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_gnt   (last_gnt),
        .enable     (state == IDLE),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign accept     = |gnt_onehot;
    assign req0_ready = gnt_onehot[PORT_IF];
    assign req1_ready = gnt_onehot[PORT_MEM];
    assign sel_addr   = (gnt_idx == PORT_MEM) ? req1_addr : req0_addr;
    assign mis        = misaligned(sel_addr[1:0]);
    assign mem_go     = accept && !mis;

    // Strobes exist only in the accept cycle; address/data are zeroed elsewhere so they never float.
    assign mem_en    = mem_go;
    assign mem_we    = mem_go && (gnt_idx == PORT_MEM) && req1_we;
    assign mem_wstrb = (mem_go && (gnt_idx == PORT_MEM)) ? req1_wstrb : 4'b0000;
    assign mem_addr  = mem_go ? sel_addr : '0;
    assign mem_wdata = (mem_go && (gnt_idx == PORT_MEM)) ? req1_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            gnt_q    <= PORT_IF;
            last_gnt <= 1'b1;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gnt_q    <= gnt_n;
            last_gnt <= last_gnt_n;
            err_q    <= err_n;
            we_q     <= we_n;
            rdata_q  <= rdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gnt_n      = gnt_q;
        last_gnt_n = last_gnt;
        err_n      = err_q;
        we_n       = we_q;
        rdata_n    = rdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    gnt_n      = gnt_idx;
                    last_gnt_n = gnt_idx;
                    we_n       = (gnt_idx == PORT_MEM) && req1_we;
                    rdata_n    = '0;
                    if (mis) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else begin
                        cnt_n   = CNT_INIT;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    rdata_n = we_q ? '0 : mem_rdata;
                    state_n = RESP;
                end
            end
            RESP: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_resp    = (state == RESP);
    assign rsp0_valid = in_resp && (gnt_q == PORT_IF);
    assign rsp1_valid = in_resp && (gnt_q == PORT_MEM);
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters at LAT=1,2,3, each driving its own behavioural memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req0_valid [3];
    logic [31:0] req0_addr  [3];
    logic        req0_ready [3];
    logic        rsp0_valid [3];
    logic [31:0] rsp0_rdata [3];
    logic        rsp0_err   [3];
    logic        req1_valid [3];
    logic        req1_we    [3];
    logic [3:0]  req1_wstrb [3];
    logic [31:0] req1_addr  [3];
    logic [31:0] req1_wdata [3];
    logic        req1_ready [3];
    logic        rsp1_valid [3];
    logic [31:0] rsp1_rdata [3];
    logic        rsp1_err   [3];
    logic        mem_en     [3];
    logic        mem_we     [3];
    logic [3:0]  mem_wstrb  [3];
    logic [31:0] mem_addr   [3];
    logic [31:0] mem_wdata  [3];
    logic [31:0] mem_rdata  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = g + 1;
        logic [31:0] mem [256];
        logic [31:0] dq  [L];
        logic        vq  [L];

        dmem_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
            .clk(clk), .rst(rst[g]),
            .req0_valid(req0_valid[g]), .req0_addr(req0_addr[g]), .req0_ready(req0_ready[g]),
            .rsp0_valid(rsp0_valid[g]), .rsp0_rdata(rsp0_rdata[g]), .rsp0_err(rsp0_err[g]),
            .req1_valid(req1_valid[g]), .req1_we(req1_we[g]), .req1_wstrb(req1_wstrb[g]),
            .req1_addr(req1_addr[g]), .req1_wdata(req1_wdata[g]), .req1_ready(req1_ready[g]),
            .rsp1_valid(rsp1_valid[g]), .rsp1_rdata(rsp1_rdata[g]), .rsp1_err(rsp1_err[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_wstrb(mem_wstrb[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Read pipe keeps running through reset so a late word still shows up on mem_rdata.
        always @(posedge clk) begin
            if (rst[g]) begin
                mem[8'h04] <= 32'hDEADBEEF;
                mem[8'h41] <= 32'h00112233;
            end else if (mem_en[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            vq[0] <= mem_en[g] && !mem_we[g];
            dq[0] <= mem[mem_addr[g][9:2]];
            for (int i = 1; i < L; i++) begin
                vq[i] <= vq[i-1];
                dq[i] <= dq[i-1];
            end
        end
        assign mem_rdata[g] = vq[L-1] ? dq[L-1] : 32'hBAD0BAD0;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input int g, input vec_t v, input string nm);
        bit got, stray;
        int n;
        @(posedge clk); #1;
        if (v.port) begin
            req1_valid[g] = 1'b1; req1_we[g] = v.we; req1_wstrb[g] = v.wstrb;
            req1_addr[g] = v.addr; req1_wdata[g] = v.wdata;
        end else begin
            req0_valid[g] = 1'b1; req0_addr[g] = v.addr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = v.port ? req1_ready[g] : req0_ready[g];
        end
        chk({nm, " accept"}, 32'(got), 32'd1);
        chk({nm, " other_ready"}, 32'(v.port ? req0_ready[g] : req1_ready[g]), 32'd0);
        chk({nm, " mem_en"}, 32'(mem_en[g]), 32'(!v.exp_err));
        chk({nm, " mem_we"}, 32'(mem_we[g]), 32'(v.port && v.we && !v.exp_err));
        if (!v.exp_err) chk({nm, " mem_addr"}, mem_addr[g], v.addr);
        if (v.we && !v.exp_err) begin
            chk({nm, " mem_wstrb"}, 32'(mem_wstrb[g]), 32'(v.wstrb));
            chk({nm, " mem_wdata"}, mem_wdata[g], v.wdata);
        end
        @(posedge clk); #1;
        req0_valid[g] = 1'b0;
        req1_valid[g] = 1'b0;
        n = 0; got = 1'b0; stray = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            got = v.port ? rsp1_valid[g] : rsp0_valid[g];
            if (mem_en[g] || mem_we[g] || (v.port ? rsp0_valid[g] : rsp1_valid[g])) stray = 1'b1;
        end
        chk({nm, " rsp_seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(n), v.exp_err ? 32'd1 : 32'(g + 2));
        chk({nm, " rdata"}, v.port ? rsp1_rdata[g] : rsp0_rdata[g], v.exp_rdata);
        chk({nm, " err"}, 32'(v.port ? rsp1_err[g] : rsp0_err[g]), 32'(v.exp_err));
        chk({nm, " quiet"}, 32'(stray), 32'd0);
    endtask

    initial begin
        int acc_cyc [4];
        int acc_prt [4];
        int rsp_cyc [4];
        int na, nr, bad, stray;
        bit got;

        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1;
            req0_valid[g] = 1'b0; req0_addr[g] = '0;
            req1_valid[g] = 1'b0; req1_we[g] = 1'b0; req1_wstrb[g] = '0;
            req1_addr[g] = '0; req1_wdata[g] = '0;
        end
        //          port we  wstrb  addr          wdata         exp_rdata     err
        vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'hCAFEF00D, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0102, 32'h0,         32'h0,         1'b1};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         32'h00112233, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'h3, 32'h0000_0020, 32'hAAAABBBB, 32'h0,         1'b0};
        vecs[6] = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'hCAFEBBBB, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'h0, 32'h0000_0021, 32'h0,         32'h0,         1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("reset rsp0_valid", 32'(rsp0_valid[0]), 32'd0);
        chk("reset rsp1_valid", 32'(rsp1_valid[0]), 32'd0);
        chk("reset rsp1_rdata", rsp1_rdata[0], 32'd0);
        chk("reset mem_en", 32'(mem_en[0]), 32'd0);

        for (int k = 0; k < 8; k++) do_txn(0, vecs[k], $sformatf("vec%0d", k));

        // Port 0 streaming alone, LAT=1: accepts every 3 cycles, ready only in IDLE.
        @(posedge clk); #1;
        req0_valid[0] = 1'b1; req0_addr[0] = 32'h104;
        na = 0; nr = 0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (na == 3) req0_valid[0] = 1'b0;
            if (req1_ready[0]) bad++;
            if (req0_ready[0] && (rsp0_valid[0] || (na > 0 && c == acc_cyc[na-1] + 1))) bad++;
            if (req0_ready[0] && na < 3) begin acc_cyc[na] = c; na++; end
            if (rsp0_valid[0]) begin
                if (rsp0_rdata[0] !== 32'h00112233) bad++;
                nr++;
            end
        end
        chk("stream accepts", 32'(na), 32'd3);
        chk("stream responses", 32'(nr), 32'd3);
        chk("stream spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("stream spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        chk("stream ready_rules", 32'(bad), 32'd0);

        // Contention on LAT=2, both valid from the cycle reset drops.
        @(posedge clk); #1;
        rst[1] = 1'b0;
        req0_valid[1] = 1'b1; req0_addr[1] = 32'h104;
        req1_valid[1] = 1'b1; req1_we[1] = 1'b0; req1_addr[1] = 32'h10;
        na = 0; nr = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (na == 4) begin req0_valid[1] = 1'b0; req1_valid[1] = 1'b0; end
            if (req0_ready[1] && req1_ready[1]) bad++;
            if ((req0_ready[1] || req1_ready[1]) && na < 4) begin
                acc_cyc[na] = c; acc_prt[na] = int'(req1_ready[1]); na++;
            end
            if ((rsp0_valid[1] || rsp1_valid[1]) && nr < 4) begin
                rsp_cyc[nr] = c;
                if (rsp1_valid[1] !== (nr % 2 == 1)) bad++;
                if ((rsp0_valid[1] ? rsp0_rdata[1] : rsp1_rdata[1]) !==
                    ((nr % 2 == 1) ? 32'hDEADBEEF : 32'h00112233)) bad++;
                nr++;
            end
        end
        chk("contend accepts", 32'(na), 32'd4);
        chk("contend responses", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("contend port%0d", k), 32'(acc_prt[k]), 32'(k % 2));
            chk($sformatf("contend rsp_lat%0d", k), 32'(rsp_cyc[k] - acc_cyc[k]), 32'd3);
            if (k > 0) chk($sformatf("contend spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);
        end
        chk("contend order_data", 32'(bad), 32'd0);

        // Reset two cycles into a LAT=3 load: the response must never appear.
        @(posedge clk); #1;
        req1_valid[2] = 1'b1; req1_we[2] = 1'b0; req1_addr[2] = 32'h10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req1_ready[2];
        end
        chk("rstmid accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("rstmid rsp0_valid", 32'(rsp0_valid[2]), 32'd0);
        chk("rstmid rsp1_valid", 32'(rsp1_valid[2]), 32'd0);
        chk("rstmid rsp1_rdata", rsp1_rdata[2], 32'd0);
        chk("rstmid rsp1_err", 32'(rsp1_err[2]), 32'd0);
        chk("rstmid mem_en", 32'(mem_en[2]), 32'd0);
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp0_valid[2] || rsp1_valid[2]) stray++;
        end
        chk("rstmid no_rsp", 32'(stray), 32'd0);
        @(posedge clk); #1;
        req0_valid[2] = 1'b1; req0_addr[2] = 32'h104;
        req1_valid[2] = 1'b1; req1_addr[2] = 32'h10;
        @(negedge clk);
        chk("rstmid tie ready0", 32'(req0_ready[2]), 32'd1);
        chk("rstmid tie ready1", 32'(req1_ready[2]), 32'd0);
        @(posedge clk); #1;
        req0_valid[2] = 1'b0;
        req1_valid[2] = 1'b0;
        repeat (8) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
